envelope_shaper: RTL and testbench

Downstream amplitude stage for the wave generators. It takes the 8-bit unsigned sample stream produced by the sawtooth or square generators and applies a gated ADSR envelope (attack, decay, sustain, release). The result is an 8-bit sample for the output DAC/PWM stage. Scaling is done about mid-scale (8'h80), so a zero envelope gives silence rather than a DC offset.

---
 rtl/envelope_shaper.sv | 135 +++++++++++++
 tb/tb_envelope_shaper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_shaper.sv
// rtl/envelope_shaper.sv - gated ADSR envelope applied about mid-scale to an 8-bit sample stream
module envelope_shaper #(
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            sample_in,
  input  logic                  gate,
  input  logic [RATE_WIDTH-1:0] attack_rate,
  input  logic [RATE_WIDTH-1:0] decay_rate,
  input  logic [7:0]            sustain_level,
  input  logic [RATE_WIDTH-1:0] release_rate,
  output logic [7:0]            sample_out,
  output logic [7:0]            envelope,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              env_q, env_d;
  logic [RATE_WIDTH-1:0]   presc_q, presc_d;
  logic [7:0]              sample_out_q, sample_out_d;
  logic [RATE_WIDTH-1:0]   rate;
  logic                    step;
  logic [7:0]              env_up, env_dn;
  logic [8:0]              s_cent;
  logic [17:0]             prod;

  always_comb begin
    rate = '0;
    case (state_q)
      S_ATTACK:  rate = attack_rate;
      S_DECAY:   rate = decay_rate;
      S_RELEASE: rate = release_rate;
      default:   rate = '0;
    endcase
  end

  assign step   = (presc_q == rate);
  assign env_up = env_q + 8'd1;
  assign env_dn = env_q - 8'd1;

  // Gate is evaluated first; a gate drop still lets this edge's step land.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      S_IDLE: begin
        env_d = 8'd0;
        if (gate) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (env_q == 8'd255) begin
          state_d = gate ? S_DECAY : S_RELEASE;
        end else begin
          if (step) env_d = env_up;
          if (!gate)                          state_d = S_RELEASE;
          else if (step && env_up == 8'd255)  state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (!gate) begin
          state_d = S_RELEASE;
          if (step && env_q != 8'd0) env_d = env_dn;
        end else if (env_q <= sustain_level) begin
          env_d   = sustain_level;
          state_d = S_SUSTAIN;
        end else if (step) begin
          env_d = env_dn;
          if (env_dn <= sustain_level) begin
            env_d   = sustain_level;
            state_d = S_SUSTAIN;
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate) state_d = S_RELEASE;
        else       env_d   = sustain_level;
      end
      S_RELEASE: begin
        if (gate) begin
          state_d = S_ATTACK;
        end else if (env_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (step) begin
          env_d = env_dn;
          if (env_dn == 8'd0) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        env_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (step || state_d != state_q) presc_d = '0;
  end

  // Centre the sample, multiply by the pre-update envelope, floor-shift by 8.
  assign s_cent = {1'b0, sample_in} - 9'd128;
  assign prod   = {{9{s_cent[8]}}, s_cent} * {10'd0, env_q};

  always_comb begin
    sample_out_d = 8'd128 + prod[15:8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      env_q        <= 8'd0;
      presc_q      <= '0;
      sample_out_q <= 8'h80;
    end else begin
      state_q      <= state_d;
      env_q        <= env_d;
      presc_q      <= presc_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign envelope   = env_q;
  assign state      = state_q;

endmodule

// File: tb/tb_envelope_shaper.sv
// tb/tb_envelope_shaper.sv - scoreboard bench for envelope_shaper
module tb_envelope_shaper;

  logic       clk;
  logic       reset_n;
  logic [7:0] sample_in;
  logic       gate;
  logic [7:0] attack_rate, decay_rate, release_rate;
  logic [7:0] sustain_level;
  logic [7:0] sample_out, envelope;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } sb_item_t;

  sb_item_t sb[$];

  localparam int SEL_ENV = 0;
  localparam int SEL_ST  = 1;
  localparam int SEL_OUT = 2;

  envelope_shaper #(.RATE_WIDTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_in(sample_in),
    .gate(gate),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .sustain_level(sustain_level),
    .release_rate(release_rate),
    .sample_out(sample_out),
    .envelope(envelope),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      SEL_ENV: return int'(envelope);
      SEL_ST:  return int'(state);
      default: return int'(sample_out);
    endcase
  endfunction

  function automatic int scale_ref(input int in, input int env);
    int p;
    p = (in - 128) * env;
    return 128 + (p >>> 8);
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic tick();
    sb_item_t it;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic run_until(input int sel, input int target, input int limit, output int n);
    n = 0;
    while (observe(sel) != target && n < limit) begin
      tick();
      n++;
    end
  endtask

  int n;
  int v;
  logic [7:0] scale_in  [3] = '{8'h00, 8'hFF, 8'h80};
  logic [7:0] scale_exp [3] = '{8'h00, 8'hFE, 8'h80};

  initial begin
    reset_n       = 1'b0;
    gate          = 1'b0;
    sample_in     = 8'hFF;
    attack_rate   = 8'd0;
    decay_rate    = 8'd0;
    release_rate  = 8'd0;
    sustain_level = 8'h40;
    #12;
    chk("reset_state", state, 0);
    chk("reset_env", envelope, 0);
    chk("reset_out", sample_out, 8'h80);
    #1 reset_n = 1'b1;
    push("idle_out_ff", SEL_OUT, 8'h80);
    push("idle_env", SEL_ENV, 0);
    tick();

    // Full ADSR with all rates 0.
    gate = 1'b1;
    push("gate_attack", SEL_ST, 1);
    push("gate_env0", SEL_ENV, 0);
    tick();
    run_until(SEL_ENV, 255, 400, n);
    chk("attack_edges", n, 255);
    chk("attack_to_decay", state, 2);
    run_until(SEL_ENV, 8'h40, 400, n);
    chk("decay_edges", n, 191);
    chk("decay_to_sustain", state, 3);
    gate = 1'b0;
    push("drop_release", SEL_ST, 4);
    push("drop_env_kept", SEL_ENV, 8'h40);
    tick();
    run_until(SEL_ENV, 0, 400, n);
    chk("release_edges", n, 64);
    chk("release_idle", state, 0);

    // Prescaler: attack_rate=3.
    attack_rate = 8'd3;
    gate = 1'b1;
    tick();
    run_until(SEL_ENV, 10, 200, n);
    chk("presc_edges", n, 40);
    repeat (3) tick();
    chk("presc_hold", envelope, 10);
    push("presc_step", SEL_ENV, 11);
    tick();

    // Asynchronous reset mid-ATTACK.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_env", envelope, 0);
    chk("async_rst_out", sample_out, 8'h80);
    gate = 1'b0;
    sample_in = 8'hFF;
    #1 reset_n = 1'b1;
    push("post_rst_out", SEL_OUT, 8'h80);
    push("post_rst_state", SEL_ST, 0);
    tick();

    // Scaling corners at envelope 255; sustain 255 exits DECAY immediately.
    attack_rate = 8'd0;
    sustain_level = 8'hFF;
    sample_in = 8'h80;
    gate = 1'b1;
    run_until(SEL_ST, 2, 400, n);
    chk("reach_decay", state, 2);
    push("decay_exit_state", SEL_ST, 3);
    push("decay_exit_env", SEL_ENV, 255);
    tick();
    for (int i = 0; i < 3; i++) begin
      sample_in = scale_in[i];
      push($sformatf("scale_%02h", scale_in[i]), SEL_OUT, int'(scale_exp[i]));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 255);
      sample_in = v[7:0];
      push($sformatf("scale_rand_%02h", v[7:0]), SEL_OUT, scale_ref(v, 255));
      tick();
    end
    sample_in = 8'h80;
    sustain_level = 8'd128;
    push("sus128_env", SEL_ENV, 128);
    tick();
    sample_in = 8'hFF;
    #1;
    chk("latency_hold", sample_out, 8'h80);
    push("scale_ff_env128", SEL_OUT, 8'hBF);
    tick();

    // Live sustain level.
    sustain_level = 8'h40;
    push("live_sus_40", SEL_ENV, 8'h40);
    tick();
    sustain_level = 8'h90;
    push("live_sus_90", SEL_ENV, 8'h90);
    push("live_sus_state", SEL_ST, 3);
    tick();

    // Retrigger from RELEASE keeps the envelope.
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    sustain_level = 8'h10;
    gate = 1'b1;
    run_until(SEL_ST, 2, 400, n);
    run_until(SEL_ENV, 200, 400, n);
    chk("retrig_at200", envelope, 200);
    gate = 1'b0;
    repeat (5) tick();
    chk("retrig_rel_env", envelope, 195);
    chk("retrig_rel_state", state, 4);
    gate = 1'b1;
    push("retrig_state", SEL_ST, 1);
    push("retrig_env", SEL_ENV, 195);
    tick();
    push("retrig_resume", SEL_ENV, 196);
    tick();

    // Gate drop on the completing ATTACK step.
    run_until(SEL_ENV, 254, 400, n);
    chk("reach_254", envelope, 254);
    gate = 1'b0;
    push("simul_state", SEL_ST, 4);
    push("simul_env", SEL_ENV, 255);
    tick();
    push("simul_rel_step", SEL_ENV, 254);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
